// File: rtl/argmax_sequencer.sv
// Streaming argmax back-end: scans one signed score per beat and reports the
// winning class as one-hot plus binary index. Optional port out_max under ARGMAX_SCORE_OUT_EN.
module argmax_sequencer #(
   parameter int N_CLASSES = 10,
   parameter int SCORE_W   = 32,
   parameter int IDX_W     = $clog2(N_CLASSES)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [SCORE_W-1:0]  in_score,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_CLASSES-1:0]       out_onehot,
   output logic [IDX_W-1:0]           out_index
`ifdef ARGMAX_SCORE_OUT_EN
   ,
   output logic signed [SCORE_W-1:0]  out_max
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(N_CLASSES - 1);
   localparam logic [N_CLASSES-1:0] ONEHOT_BASE = N_CLASSES'(1);

   state_t                      state_q, state_d;
   logic [IDX_W-1:0]            count_q, count_d;
   logic signed [SCORE_W-1:0]   max_q, max_d;
   logic [IDX_W-1:0]            idx_q, idx_d;

   logic                        busy_q, busy_d;
   logic                        in_ready_q, in_ready_d;
   logic                        out_valid_q, out_valid_d;
   logic [N_CLASSES-1:0]        out_onehot_q, out_onehot_d;
   logic [IDX_W-1:0]            out_index_q, out_index_d;
`ifdef ARGMAX_SCORE_OUT_EN
   logic signed [SCORE_W-1:0]   out_max_q, out_max_d;
`endif

   // Next-state logic for the frame FSM and the running maximum
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      max_d   = max_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SCAN;
               count_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (in_valid) begin
               // First beat seeds the maximum; later beats need a strictly greater score
               if ((count_q == '0) || (in_score > max_q)) begin
                  max_d = in_score;
                  idx_d = count_q;
               end else begin
                  max_d = max_q;
               end
               if (count_q == LAST_IDX) begin
                  count_d = '0;
                  state_d = ST_DONE;
               end else begin
                  count_d = count_q + IDX_W'(1);
               end
            end else begin
               count_d = count_q;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               if (start) begin
                  state_d = ST_SCAN;
                  count_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   // Output values decoded from the next state so they can be registered
   always_comb begin
      busy_d       = (state_d != ST_IDLE);
      in_ready_d   = (state_d == ST_SCAN);
      out_valid_d  = (state_d == ST_DONE);
      out_onehot_d = '0;
      out_index_d  = '0;
`ifdef ARGMAX_SCORE_OUT_EN
      out_max_d    = '0;
`endif
      if (state_d == ST_DONE) begin
         out_onehot_d = ONEHOT_BASE << idx_d;
         out_index_d  = idx_d;
`ifdef ARGMAX_SCORE_OUT_EN
         out_max_d    = max_d;
`endif
      end else begin
         out_index_d  = '0;
      end
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         max_q        <= '0;
         idx_q        <= '0;
         busy_q       <= 1'b0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_onehot_q <= '0;
         out_index_q  <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
         out_max_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         max_q        <= max_d;
         idx_q        <= idx_d;
         busy_q       <= busy_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_onehot_q <= out_onehot_d;
         out_index_q  <= out_index_d;
`ifdef ARGMAX_SCORE_OUT_EN
         out_max_q    <= out_max_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_onehot = out_onehot_q;
   assign out_index  = out_index_q;
`ifdef ARGMAX_SCORE_OUT_EN
   assign out_max    = out_max_q;
`endif

endmodule

// File: tb/tb_argmax_sequencer.sv
// Scoreboard bench for argmax_sequencer: randomized and directed frames,
// expected results from a plain argmax model, checked by a separate monitor.
module tb_argmax_sequencer;

   localparam int N   = 10;
   localparam int SW  = 32;
   localparam int IW  = $clog2(N);

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic                  busy;
   logic                  in_valid;
   logic                  in_ready;
   logic signed [SW-1:0]  in_score;
   logic                  out_valid;
   logic                  out_ready;
   logic [N-1:0]          out_onehot;
   logic [IW-1:0]         out_index;
`ifdef ARGMAX_SCORE_OUT_EN
   logic signed [SW-1:0]  out_max;
`endif

   typedef struct {
      int                   idx;
      logic signed [SW-1:0] mx;
   } exp_t;

   exp_t                 sb[$];
   logic signed [SW-1:0] frame_s [N];
   int                   checks = 0;
   int                   errors = 0;

   argmax_sequencer #(.N_CLASSES(N), .SCORE_W(SW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_score   (in_score),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .out_index  (out_index)
`ifdef ARGMAX_SCORE_OUT_EN
      ,
      .out_max    (out_max)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: find the largest score, then the first class holding it
   task automatic push_expected();
      exp_t e;
      logic signed [SW-1:0] best;
      best = frame_s[0];
      foreach (frame_s[k]) if (frame_s[k] > best) best = frame_s[k];
      e.idx = -1;
      foreach (frame_s[k]) if (e.idx < 0 && frame_s[k] == best) e.idx = k;
      e.mx = best;
      sb.push_back(e);
   endtask

   // Monitor: compare presented results against the scoreboard head
   always @(negedge clk) begin
      logic [N-1:0] one;
      one = N'(1);
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 64'sd1, 64'sd0);
         end else begin
            chk("out_index", out_index, sb[0].idx);
            chk("out_onehot", out_onehot, one << sb[0].idx);
`ifdef ARGMAX_SCORE_OUT_EN
            chk("out_max", out_max, sb[0].mx);
`endif
            if (out_ready === 1'b1) void'(sb.pop_front());
         end
      end else begin
         chk("idle_onehot_zero", out_onehot, 64'sd0);
         chk("idle_index_zero", out_index, 64'sd0);
`ifdef ARGMAX_SCORE_OUT_EN
         chk("idle_max_zero", out_max, 64'sd0);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("scan_busy", busy, 64'sd1);
      chk("scan_in_ready", in_ready, 64'sd1);
      chk("scan_out_valid", out_valid, 64'sd0);
   endtask

   task automatic drive_beats(input int bubble_pct);
      push_expected();
      for (int k = 0; k < N; k++) begin
         if ($urandom_range(99) < bubble_pct) begin
            in_valid = 1'b0;
            in_score = $urandom;
            tick();
         end
         in_valid = 1'b1;
         in_score = frame_s[k];
         tick();
      end
      in_valid = 1'b0;
      chk("latency_out_valid", out_valid, 64'sd1);
   endtask

   task automatic finish_frame(input int hold, input bit chain);
      out_ready = 1'b0;
      repeat (hold) tick();
      chk("hold_out_valid", out_valid, 64'sd1);
      out_ready = 1'b1;
      start     = chain;
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      chk("post_hs_out_valid", out_valid, 64'sd0);
      chk("post_hs_busy", busy, chain);
      chk("post_hs_in_ready", in_ready, chain);
   endtask

   task automatic rand_frame();
      int mode;
      logic signed [SW-1:0] picks [4];
      picks[0] = 32'sh8000_0000;
      picks[1] = 32'sh7FFF_FFFF;
      picks[2] = 32'sd0;
      picks[3] = -32'sd1;
      mode = int'($urandom_range(2));
      for (int k = 0; k < N; k++) begin
         case (mode)
            0:       frame_s[k] = $urandom;
            1:       frame_s[k] = $signed(32'($urandom_range(6))) - 32'sd3;
            default: frame_s[k] = picks[$urandom_range(3)];
         endcase
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_score = '0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_busy", busy, 64'sd0);
      chk("rst_in_ready", in_ready, 64'sd0);
      chk("rst_out_valid", out_valid, 64'sd0);
      rst = 1'b1;
      tick();
      chk("idle_in_ready", in_ready, 64'sd0);

      for (int k = 0; k < N; k++) frame_s[k] = 32'(k);
      start_frame(); drive_beats(0); finish_frame(0, 1'b0);

      frame_s = '{32'sd5, -32'sd3, 32'sd7, 32'sd7, 32'sd2, 32'sd0, 32'sd0, 32'sd0, 32'sd0, -32'sd1};
      start_frame(); drive_beats(0); finish_frame(1, 1'b0);

      for (int k = 0; k < N; k++) frame_s[k] = 32'sh8000_0000;
      start_frame(); drive_beats(0); finish_frame(0, 1'b0);

      for (int k = 0; k < N; k++) frame_s[k] = $signed(32'(k)) - 32'sd9;
      start_frame(); drive_beats(0); finish_frame(0, 1'b0);

      frame_s = '{32'sd3, 32'sd1, 32'sd4, 32'sd1, 32'sd5, 32'sd9, 32'sd2, 32'sd6, 32'sd5, 32'sd3};
      start_frame(); drive_beats(100); finish_frame(5, 1'b1);

      // Back-to-back frame launched on the handshake above: no start pulse needed
      rand_frame();
      drive_beats(30); finish_frame(2, 1'b0);

      // Abort mid-frame after five beats; nothing may be reported for it
      start_frame();
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_score = 32'sh7FFF_FFFF;
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("abort_busy", busy, 64'sd0);
      chk("abort_in_ready", in_ready, 64'sd0);
      chk("abort_out_valid", out_valid, 64'sd0);
      tick();
      rst = 1'b1;
      tick();
      chk("after_abort_busy", busy, 64'sd0);
      for (int k = 0; k < N; k++) frame_s[k] = -32'sd50 + $signed(32'(k % 3));
      start_frame(); drive_beats(0); finish_frame(0, 1'b0);

      for (int f = 0; f < 25; f++) begin
         rand_frame();
         start_frame();
         drive_beats(int'($urandom_range(40)));
         finish_frame(int'($urandom_range(3)), 1'b0);
      end

      repeat (2) tick();
      chk("scoreboard_empty", sb.size(), 64'sd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout actual running required finished");
      $fatal(1, "watchdog");
   end

endmodule
